// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and control encodings.
// Instantiators build CTRL_FLUSH_VALUE from these constants.
package pipe_pkg;
  typedef enum logic [1:0] {PS_EMPTY = 2'd0, PS_ONE = 2'd1, PS_TWO = 2'd2} pipe_state_t;

  localparam logic [1:0] PCSRC_REG     = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;
  localparam logic [1:0] PCSRC_NEXT_PC = 2'b11;

  // Safe 8-bit control word: PC source in bits [1:0], all write enables off.
  function automatic logic [7:0] ctrl_safe8();
    return {6'b0, PCSRC_NEXT_PC};
  endfunction
endpackage

// File: rtl/pipe_reg_entry.sv
// One ctrl+data register slice. Ctrl clears to the safe value; data clear is optional.
module pipe_reg_entry #(
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    CTRL_WIDTH       = 8,
  parameter logic [CTRL_WIDTH-1:0] CTRL_FLUSH_VALUE = '0,
  parameter bit                    CLEAR_DATA       = 1'b0
) (
  input  logic                  clk,
  input  logic                  load_i,
  input  logic                  clr_ctrl_i,
  input  logic                  clr_data_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (clr_ctrl_i)  ctrl_q <= CTRL_FLUSH_VALUE;
    else if (load_i) ctrl_q <= ctrl_i;
  end

  // A clear request always blocks the load, so flushed data never captures the input.
  always_ff @(posedge clk) begin
    if (clr_data_i) begin
      if (CLEAR_DATA) data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with optional 2-entry skid buffer and flush.
// With SKID_EN=1, in_ready depends only on the state register.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH          = 32,
  parameter int                    CTRL_WIDTH          = 8,
  parameter logic [CTRL_WIDTH-1:0] CTRL_FLUSH_VALUE    = '0,
  parameter bit                    SKID_EN             = 1'b1,
  parameter bit                    CLEAR_DATA_ON_FLUSH = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);
  pipe_state_t state_q, state_d;

  logic in_xfer, out_xfer, kill;
  logic main_load, main_clr, main_sel_skid, skid_load;
  logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DATA_WIDTH-1:0] main_data, skid_data, main_data_d;

  assign kill      = rst | flush;
  assign out_valid = (state_q != PS_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  generate
    if (SKID_EN) begin : g_rdy_reg
      assign in_ready = (state_q != PS_TWO);
    end else begin : g_rdy_comb
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    case (state_q)
      PS_EMPTY: if (in_xfer) begin
        state_d   = PS_ONE;
        main_load = 1'b1;
      end
      PS_ONE: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (in_xfer) begin
          state_d   = PS_TWO;
          skid_load = 1'b1;
        end else if (out_xfer) begin
          state_d  = PS_EMPTY;
          main_clr = 1'b1;
        end
      end
      PS_TWO: if (out_xfer) begin
        state_d       = PS_ONE;
        main_load     = 1'b1;
        main_sel_skid = 1'b1;
      end
      default: state_d = PS_EMPTY;
    endcase
    if (kill) state_d = PS_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= PS_EMPTY;
    else     state_q <= state_d;
  end

  assign main_ctrl_d = main_sel_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = main_sel_skid ? skid_data : in_data;

  pipe_reg_entry #(
    .DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH),
    .CTRL_FLUSH_VALUE(CTRL_FLUSH_VALUE), .CLEAR_DATA(CLEAR_DATA_ON_FLUSH)
  ) u_main (
    .clk(clk), .load_i(main_load), .clr_ctrl_i(kill | main_clr), .clr_data_i(kill),
    .ctrl_i(main_ctrl_d), .data_i(main_data_d), .ctrl_o(main_ctrl), .data_o(main_data)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_reg_entry #(
        .DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH),
        .CTRL_FLUSH_VALUE(CTRL_FLUSH_VALUE), .CLEAR_DATA(CLEAR_DATA_ON_FLUSH)
      ) u_skid (
        .clk(clk), .load_i(skid_load), .clr_ctrl_i(kill), .clr_data_i(kill),
        .ctrl_i(in_ctrl), .data_i(in_data), .ctrl_o(skid_ctrl), .data_o(skid_data)
      );
    end else begin : g_noskid
      assign skid_ctrl = CTRL_FLUSH_VALUE;
      assign skid_data = '0;
    end
  endgenerate

  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = state_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table plus scoreboarded random traffic,
// on a skid instance (data clear on) and a single-register instance.
module tb_pipe_stage_skid;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_flush, a_iv, a_ir, a_ov, a_or;
  logic [7:0] a_ic, a_oc;
  logic [31:0] a_id, a_od;
  logic [1:0] a_occ;
  logic b_rst, b_flush, b_iv, b_ir, b_ov, b_or;
  logic [7:0] b_ic, b_oc;
  logic [31:0] b_id, b_od;
  logic [1:0] b_occ;

  pipe_stage_skid #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .CTRL_FLUSH_VALUE(8'h03),
                    .SKID_EN(1'b1), .CLEAR_DATA_ON_FLUSH(1'b1)) dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
    .in_ctrl(a_ic), .in_data(a_id), .out_valid(a_ov), .out_ready(a_or),
    .out_ctrl(a_oc), .out_data(a_od), .occupancy(a_occ));

  pipe_stage_skid #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .CTRL_FLUSH_VALUE(8'h03),
                    .SKID_EN(1'b0), .CLEAR_DATA_ON_FLUSH(1'b0)) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
    .in_ctrl(b_ic), .in_data(b_id), .out_valid(b_ov), .out_ready(b_or),
    .out_ctrl(b_oc), .out_data(b_od), .occupancy(b_occ));

  typedef struct {
    logic rst, flush, iv, orr;
    logic [7:0] ic;
    logic [31:0] id;
    logic ov, ir;
    logic [1:0] occ;
    logic [7:0] oc;
    logic [31:0] od;
  } vec_t;

  typedef struct packed {
    logic [7:0] c;
    logic [31:0] d;
  } ent_t;

  vec_t vt[17];
  ent_t qa[$];
  ent_t qb[$];
  int checks = 0;
  int errors = 0;
  int b_pops = 0;

  function automatic vec_t v(input logic rst, flush, iv, orr, input logic [7:0] ic,
                             input logic [31:0] id, input logic ov, ir,
                             input logic [1:0] occ, input logic [7:0] oc, input logic [31:0] od);
    vec_t r;
    r.rst = rst; r.flush = flush; r.iv = iv; r.orr = orr; r.ic = ic; r.id = id;
    r.ov = ov; r.ir = ir; r.occ = occ; r.oc = oc; r.od = od;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc_a(input logic iv, input logic orr, input logic [7:0] ic, input logic [31:0] id);
    ent_t e;
    @(negedge clk);
    a_iv = iv; a_or = orr; a_ic = ic; a_id = id;
    #1;
    if (!a_ov) chk("a_idle_ctrl", {24'b0, a_oc}, 32'h03);
    chk("a_occ_vs_sb", {30'b0, a_occ}, qa.size());
    if (a_ov && a_or) begin
      if (qa.size() == 0) chk("a_unexpected_out", {31'b0, a_ov}, 32'h0);
      else begin
        e = qa.pop_front();
        chk("a_out_ctrl", {24'b0, a_oc}, {24'b0, e.c});
        chk("a_out_data", a_od, e.d);
      end
    end
    if (a_iv && a_ir) qa.push_back({a_ic, a_id});
  endtask

  task automatic cyc_b(input logic iv, input logic orr, input logic [7:0] ic, input logic [31:0] id);
    ent_t e;
    @(negedge clk);
    b_iv = iv; b_or = orr; b_ic = ic; b_id = id;
    #1;
    chk("b_in_ready", {31'b0, b_ir}, {31'b0, !b_ov | b_or});
    if (!b_ov) chk("b_idle_ctrl", {24'b0, b_oc}, 32'h03);
    chk("b_occ_vs_sb", {30'b0, b_occ}, qb.size());
    if (b_ov && b_or) begin
      b_pops++;
      if (qb.size() == 0) chk("b_unexpected_out", {31'b0, b_ov}, 32'h0);
      else begin
        e = qb.pop_front();
        chk("b_out_ctrl", {24'b0, b_oc}, {24'b0, e.c});
        chk("b_out_data", b_od, e.d);
      end
    end
    if (b_iv && b_ir) qb.push_back({b_ic, b_id});
  endtask

  initial begin
    a_rst = 1; a_flush = 0; a_iv = 0; a_or = 0; a_ic = 0; a_id = 0;
    b_rst = 1; b_flush = 0; b_iv = 0; b_or = 0; b_ic = 0; b_id = 0;

    //          rst flush iv or  ic     id              ov ir occ oc     od
    vt[0]  = v(1, 0, 0, 0, 8'h00, 32'h0,          0, 1, 0, 8'h03, 32'h0);
    vt[1]  = v(0, 0, 1, 1, 8'h5A, 32'hDEADBEEF,   1, 1, 1, 8'h5A, 32'hDEADBEEF);
    vt[2]  = v(0, 0, 1, 1, 8'hA1, 32'hAAAA0001,   1, 1, 1, 8'hA1, 32'hAAAA0001);
    vt[3]  = v(0, 0, 1, 0, 8'hB2, 32'hBBBB0002,   1, 0, 2, 8'hA1, 32'hAAAA0001);
    vt[4]  = v(0, 0, 1, 0, 8'hC3, 32'hCCCC0003,   1, 0, 2, 8'hA1, 32'hAAAA0001);
    vt[5]  = v(0, 0, 1, 0, 8'hC3, 32'hCCCC0003,   1, 0, 2, 8'hA1, 32'hAAAA0001);
    vt[6]  = v(0, 0, 1, 1, 8'hC3, 32'hCCCC0003,   1, 1, 1, 8'hB2, 32'hBBBB0002);
    vt[7]  = v(0, 0, 1, 1, 8'hC3, 32'hCCCC0003,   1, 1, 1, 8'hC3, 32'hCCCC0003);
    vt[8]  = v(0, 0, 0, 1, 8'hC3, 32'hCCCC0003,   0, 1, 0, 8'h03, 32'hCCCC0003);
    vt[9]  = v(0, 0, 1, 0, 8'hD1, 32'hDDDD0004,   1, 1, 1, 8'hD1, 32'hDDDD0004);
    vt[10] = v(0, 0, 1, 0, 8'hE2, 32'hEEEE0005,   1, 0, 2, 8'hD1, 32'hDDDD0004);
    vt[11] = v(0, 1, 1, 0, 8'hF3, 32'hFFFF0006,   0, 1, 0, 8'h03, 32'h0);
    vt[12] = v(0, 0, 1, 0, 8'h64, 32'h44440007,   1, 1, 1, 8'h64, 32'h44440007);
    vt[13] = v(0, 1, 1, 0, 8'h75, 32'h55550008,   0, 1, 0, 8'h03, 32'h0);
    vt[14] = v(0, 0, 0, 1, 8'h75, 32'h55550008,   0, 1, 0, 8'h03, 32'h0);
    vt[15] = v(0, 0, 1, 0, 8'h86, 32'h66660009,   1, 1, 1, 8'h86, 32'h66660009);
    vt[16] = v(1, 1, 0, 0, 8'h00, 32'h0,          0, 1, 0, 8'h03, 32'h0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      a_rst = vt[i].rst; a_flush = vt[i].flush; a_iv = vt[i].iv; a_or = vt[i].orr;
      a_ic = vt[i].ic; a_id = vt[i].id;
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_out_valid", i), {31'b0, a_ov}, {31'b0, vt[i].ov});
      chk($sformatf("r%0d_in_ready", i), {31'b0, a_ir}, {31'b0, vt[i].ir});
      chk($sformatf("r%0d_occupancy", i), {30'b0, a_occ}, {30'b0, vt[i].occ});
      chk($sformatf("r%0d_out_ctrl", i), {24'b0, a_oc}, {24'b0, vt[i].oc});
      chk($sformatf("r%0d_out_data", i), a_od, vt[i].od);
    end
    @(negedge clk);
    a_rst = 0; a_flush = 0; a_iv = 0;

    for (int i = 0; i < 10000; i++)
      cyc_a(($urandom % 4) != 0, ($urandom % 3) != 0, 8'($urandom), $urandom);
    for (int i = 0; i < 6; i++) cyc_a(1'b0, 1'b1, 8'h00, 32'h0);
    chk("a_drain_sb_empty", qa.size(), 32'h0);
    chk("a_drain_out_valid", {31'b0, a_ov}, 32'h0);

    @(negedge clk);
    b_rst = 1;
    @(posedge clk);
    #1;
    chk("b_rst_out_valid", {31'b0, b_ov}, 32'h0);
    chk("b_rst_in_ready", {31'b0, b_ir}, 32'h1);
    chk("b_rst_occupancy", {30'b0, b_occ}, 32'h0);
    chk("b_rst_out_ctrl", {24'b0, b_oc}, 32'h03);
    @(negedge clk);
    b_rst = 0;
    cyc_b(1'b1, 1'b0, 8'h77, 32'h12345678);
    @(negedge clk);
    b_iv = 1; b_or = 0; b_ic = 8'h88; b_id = 32'h87654321;
    #1;
    chk("b_stall_in_ready", {31'b0, b_ir}, 32'h0);
    chk("b_stall_out_ctrl", {24'b0, b_oc}, 32'h77);
    chk("b_stall_out_data", b_od, 32'h12345678);
    chk("b_stall_occupancy", {30'b0, b_occ}, 32'h1);
    b_or = 1;
    #1;
    chk("b_release_in_ready", {31'b0, b_ir}, 32'h1);
    b_or = 0;
    b_pops = 0;
    for (int i = 0; i < 6; i++) cyc_b(1'b1, 1'b1, 8'($urandom), $urandom);
    chk("b_b2b_rate", b_pops, 32'd6);
    for (int i = 0; i < 3000; i++)
      cyc_b(($urandom % 4) != 0, ($urandom % 3) != 0, 8'($urandom), $urandom);
    for (int i = 0; i < 4; i++) cyc_b(1'b0, 1'b1, 8'h00, 32'h0);
    chk("b_drain_sb_empty", qb.size(), 32'h0);
    chk("b_drain_out_valid", {31'b0, b_ov}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
